// File: rtl/ctr4_bcd_if.sv
// ctr4_bcd_if: groups the count-enable, optional load bus and the counter
// outputs of ctr4_bcd. The load signals exist only when CTR4_BCD_LOAD_EN
// is defined.
interface ctr4_bcd_if;
    logic       en;
    logic [3:0] q4;
    logic [3:0] qbcd;
    logic       tc4;
    logic       tcbcd;
`ifdef CTR4_BCD_LOAD_EN
    logic       load;
    logic [3:0] d4;
    logic [3:0] dbcd;
`endif

`ifdef CTR4_BCD_LOAD_EN
    modport master (output en, output load, output d4, output dbcd,
                    input q4, input qbcd, input tc4, input tcbcd);
    modport slave  (input en, input load, input d4, input dbcd,
                    output q4, output qbcd, output tc4, output tcbcd);
`else
    modport master (output en, input q4, input qbcd, input tc4, input tcbcd);
    modport slave  (input en, output q4, output qbcd, output tc4, output tcbcd);
`endif
endinterface

// File: rtl/ctr4_bcd.sv
// ctr4_bcd: a 4-bit binary counter and a decade (BCD) counter sharing one
// clock, one asynchronous active-low reset and one count enable.
// Terminal counts are combinational from the registered value and en, and
// are held low while reset is asserted.
// Optional feature: define CTR4_BCD_LOAD_EN to add a synchronous parallel
// load (load/d4/dbcd) that takes priority over en.
module ctr4_bcd #(
    parameter logic [3:0] Q4_INIT  = 4'd0,  // reset value of q4 (0..15)
    parameter logic [3:0] BCD_INIT = 4'd0   // reset value of qbcd (0..9, 10..15 -> 0)
) (
    input logic        clk,    // single clock, rising edge
    input logic        reset,  // asynchronous active-low reset
    ctr4_bcd_if.slave  bus     // en, optional load bus, counter outputs
);

    // Out-of-range decade init values collapse to zero.
    localparam logic [3:0] BCD_RST = (BCD_INIT > 4'd9) ? 4'd0 : BCD_INIT;

    logic [3:0] q4_q;
    logic [3:0] q4_d;
    logic [3:0] qbcd_q;
    logic [3:0] qbcd_d;

    // Next-state: load (if present) beats en; decade counter wraps 9->0 and
    // recovers from any illegal 10..15 value on the next step.
    always_comb begin
        q4_d   = q4_q;
        qbcd_d = qbcd_q;
`ifdef CTR4_BCD_LOAD_EN
        if (bus.load) begin
            q4_d   = bus.d4;
            qbcd_d = (bus.dbcd > 4'd9) ? 4'd0 : bus.dbcd;
        end else
`endif
        if (bus.en) begin
            q4_d   = q4_q + 4'd1;
            qbcd_d = (qbcd_q >= 4'd9) ? 4'd0 : (qbcd_q + 4'd1);
        end
    end

    // Count registers; reset forces init values immediately, ignoring clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q4_q   <= Q4_INIT;
            qbcd_q <= BCD_RST;
        end else begin
            q4_q   <= q4_d;
            qbcd_q <= qbcd_d;
        end
    end

    assign bus.q4    = q4_q;
    assign bus.qbcd  = qbcd_q;
    assign bus.tc4   = reset & bus.en & (q4_q == 4'd15);
    assign bus.tcbcd = reset & bus.en & (qbcd_q == 4'd9);

endmodule

// File: tb/tb_ctr4_bcd.sv
// tb_ctr4_bcd: directed vector table for the enabled count run plus
// hand-written sequences for reset, hold, mid-count reset and load.
module tb_ctr4_bcd;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ctr4_bcd_if bif ();
    ctr4_bcd_if bif2 ();

    ctr4_bcd dut (.clk(clk), .reset(reset), .bus(bif.slave));

    // Second instance with non-zero / out-of-range init values.
    ctr4_bcd #(.Q4_INIT(4'd15), .BCD_INIT(4'd12)) dut2 (
        .clk(clk), .reset(reset), .bus(bif2.slave));

    assign bif2.en = bif.en;
`ifdef CTR4_BCD_LOAD_EN
    assign bif2.load = 1'b0;
    assign bif2.d4   = 4'd0;
    assign bif2.dbcd = 4'd0;
`endif

    typedef struct {
        logic       en;
        logic [3:0] q4;
        logic [3:0] qbcd;
        logic       tc4;
        logic       tcbcd;
    } vec_t;

    vec_t vec [20];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] q4, input logic [3:0] qbcd,
                           input logic tc4, input logic tcbcd);
        chk({name, ".q4"},    32'(bif.q4),    32'(q4));
        chk({name, ".qbcd"},  32'(bif.qbcd),  32'(qbcd));
        chk({name, ".tc4"},   32'(bif.tc4),   32'(tc4));
        chk({name, ".tcbcd"}, 32'(bif.tcbcd), 32'(tcbcd));
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Enabled run from 0: 20 edges, hand-computed values.
        vec[0]  = '{1'b1, 4'd1,  4'd1, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 4'd2,  4'd2, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 4'd3,  4'd3, 1'b0, 1'b0};
        vec[3]  = '{1'b1, 4'd4,  4'd4, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 4'd5,  4'd5, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 4'd6,  4'd6, 1'b0, 1'b0};
        vec[6]  = '{1'b1, 4'd7,  4'd7, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 4'd8,  4'd8, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 4'd9,  4'd9, 1'b0, 1'b1};
        vec[9]  = '{1'b1, 4'd10, 4'd0, 1'b0, 1'b0};
        vec[10] = '{1'b1, 4'd11, 4'd1, 1'b0, 1'b0};
        vec[11] = '{1'b1, 4'd12, 4'd2, 1'b0, 1'b0};
        vec[12] = '{1'b1, 4'd13, 4'd3, 1'b0, 1'b0};
        vec[13] = '{1'b1, 4'd14, 4'd4, 1'b0, 1'b0};
        vec[14] = '{1'b1, 4'd15, 4'd5, 1'b1, 1'b0};
        vec[15] = '{1'b1, 4'd0,  4'd6, 1'b0, 1'b0};
        vec[16] = '{1'b1, 4'd1,  4'd7, 1'b0, 1'b0};
        vec[17] = '{1'b1, 4'd2,  4'd8, 1'b0, 1'b0};
        vec[18] = '{1'b1, 4'd3,  4'd9, 1'b0, 1'b1};
        vec[19] = '{1'b1, 4'd4,  4'd0, 1'b0, 1'b0};

        reset = 1'b1;
        bif.en = 1'b1;
`ifdef CTR4_BCD_LOAD_EN
        bif.load = 1'b0;
        bif.d4   = 4'd0;
        bif.dbcd = 4'd0;
`endif

        // Asynchronous reset between edges.
        #1 reset = 1'b0;
        #1;
        chk_all("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
        chk("init2.q4",   32'(bif2.q4),   32'd15);
        chk("init2.qbcd", 32'(bif2.qbcd), 32'd0);
        chk("init2.tc4_in_rst", 32'(bif2.tc4), 32'd0);
        for (int i = 0; i < 3; i++) begin
            edge_wait();
            chk_all("rst_hold", 4'd0, 4'd0, 1'b0, 1'b0);
        end

        // Release between edges: no increment from the release itself.
        reset = 1'b1;
        #1;
        chk_all("rst_release", 4'd0, 4'd0, 1'b0, 1'b0);
        chk("init2.tc4_after_rel", 32'(bif2.tc4), 32'd1);

        // Table-driven enabled run.
        for (int i = 0; i < 20; i++) begin
            bif.en = vec[i].en;
            edge_wait();
            chk_all($sformatf("run[%0d]", i), vec[i].q4, vec[i].qbcd, vec[i].tc4, vec[i].tcbcd);
            if (i == 0) begin
                chk("init2.wrap_q4",   32'(bif2.q4),   32'd0);
                chk("init2.step_qbcd", 32'(bif2.qbcd), 32'd1);
            end
        end

        // Hold: bring both to 7, then en=0 for 5 edges.
        reset = 1'b0;
        #1 reset = 1'b1;
        bif.en = 1'b1;
        for (int i = 0; i < 7; i++) edge_wait();
        chk_all("to7", 4'd7, 4'd7, 1'b0, 1'b0);
        bif.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_wait();
            chk_all("hold", 4'd7, 4'd7, 1'b0, 1'b0);
        end

        // Mid-count reset: 75 edges from 0 gives q4=11, qbcd=5.
        reset = 1'b0;
        #1 reset = 1'b1;
        bif.en = 1'b1;
        for (int i = 0; i < 75; i++) edge_wait();
        chk_all("pre_mid_rst", 4'd11, 4'd5, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk_all("mid_rst", 4'd0, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        edge_wait();
        chk_all("after_mid_rst", 4'd1, 4'd1, 1'b0, 1'b0);

`ifdef CTR4_BCD_LOAD_EN
        // Load beats en; dbcd > 9 loads 0.
        bif.load = 1'b1;
        bif.d4   = 4'd14;
        bif.dbcd = 4'd12;
        bif.en   = 1'b1;
        edge_wait();
        bif.load = 1'b0;
        chk_all("load", 4'd14, 4'd0, 1'b0, 1'b0);
        edge_wait();
        chk_all("after_load", 4'd15, 4'd1, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
